uart_tx_sched: RTL and testbench
================================

Name: uart_tx_sched

Overview:
- MMIO bus master that drains a local byte FIFO into the UART through the peripheral bus.
- Per byte: polls UART STATUS (base+2) until tx_busy (bit0) reads 0, then writes the byte to UART DATA (base+0).
- Sits between a byte producer (CPU-side shim or debug logger) and the periph_bus slave port, so software no longer busy-waits on tx_busy.

Parameters:
- FIFO_DEPTH, 8, byte FIFO entries; power of two, at least 2.
- UART_BASE, 16'h8300, UART word-aligned base; DATA at +0, STATUS at +2.
- POLL_LIMIT, 4096, maximum STATUS reads per byte before timeout.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_push  in  1  enqueue strobe, one byte per cycle.
- i_push_data  in  8  byte to enqueue.
- o_full  out  1  FIFO full.
- o_empty  out  1  FIFO empty.
- o_level  out  $clog2(FIFO_DEPTH+1)  FIFO occupancy.
- o_busy  out  1  FSM not in IDLE.
- o_ovf  out  1  sticky: push dropped while full.
- o_timeout  out  1  sticky: POLL_LIMIT exceeded.
- i_clr_err  in  1  clears o_ovf and o_timeout.
- o_sel, o_we, o_re  out  1 each  bus request strobes.
- o_addr  out  16  bus address.
- o_wdata  out  16  bus write data.
- i_rdata  in  16  bus read data.
- i_rdy  in  1  bus transfer complete.

Behaviour:
- Reset: FIFO empty, o_level=0, o_empty=1, o_full=0, o_busy=0, o_ovf=0, o_timeout=0, all bus strobes 0, o_addr=0, o_wdata=0, FSM=IDLE, poll counter=0.
- Reset asserted mid-transfer: bus strobes drop asynchronously; FIFO contents are discarded.
- Bus rule: o_sel, o_we, o_re, o_addr and o_wdata are registered and held stable until a rising edge samples i_rdy=1. i_rdata is captured on that same edge. Strobes deassert the following cycle.
- FIFO: push accepted when i_push=1 and not full; a push while full is dropped and sets o_ovf, including when a pop happens in the same cycle. Simultaneous push and pop at level L (0<L<DEPTH) leaves the level at L. Pointers wrap modulo FIFO_DEPTH.
- FSM states and transitions:
  - IDLE: if not empty, go to RD_STAT; else stay.
  - RD_STAT: o_sel=o_re=1, o_addr=UART_BASE+2. When i_rdy=1, go to CHK with the status captured.
  - CHK (one cycle):
    - bit0=0: go to WR_DATA and clear the poll counter.
    - bit0=1 and counter < POLL_LIMIT-1: increment the counter and go to RD_STAT.
    - Otherwise: set o_timeout, pop and discard the head byte, clear the counter, go to IDLE.
  - WR_DATA: o_sel=o_we=1, o_addr=UART_BASE, o_wdata={8'h00, head}. When i_rdy=1, pop the FIFO and go to IDLE.
- Minimum latency from push into an empty FIFO to DATA write strobe: 4 cycles with i_rdy tied high (IDLE → RD_STAT → CHK → WR_DATA).
- Bytes leave strictly in FIFO order.
- i_clr_err clears the sticky flags. A new error event in the same cycle wins: the flag stays set.

Optional Feature:
- UART_RX_POLL_EN defined:
  - Adds ports o_rx_valid (out, 1), o_rx_data (out, 8) and i_rx_ready (in, 1).
  - In CHK, if status bit1 (rx_pending)=1 and the RX holding register is empty, the FSM goes to RD_DATA (read UART_BASE, latch i_rdata[7:0], set o_rx_valid), then CLR_RX (write 16'h0002 to UART_BASE+2).
  - After CLR_RX the FSM returns to RD_STAT. RX service takes priority over TX in CHK.
  - IDLE also enters RD_STAT every 64 cycles when the FIFO is empty.
  - o_rx_valid clears on i_rx_ready.
- UART_RX_POLL_EN undefined: RX ports are absent and status bit1 is ignored.

Decomposition:
- Package uart_sched_pkg holds:
  - state enum (IDLE, RD_STAT, CHK, WR_DATA, RD_DATA, CLR_RX);
  - offsets UART_DATA_OFF=16'h0 and UART_STAT_OFF=16'h2;
  - status bit indices STAT_TX_BUSY=0 and STAT_RX_PEND=1.
- One sub-module, sync_fifo_byte: parameterised depth; push/pop/full/empty/level; no bus knowledge.

Test Plan:
- Push 8'h5A with slave model tx_busy=0 and i_rdy=1 → read of 16'h8302, then write of 16'h005A to 16'h8300, o_busy returns to 0, o_empty=1.
- Push 8'h41, 8'h42, 8'h43 with tx_busy held 1 for 20 cycles after each write → exactly three DATA writes in order 0041, 0042, 0043; no write while busy=1.
- Push 9 bytes back-to-back with i_rdy=0 → o_full=1 after 8, o_ovf=1, o_level=8; i_clr_err clears o_ovf.
- tx_busy stuck at 1, POLL_LIMIT=16 → exactly 16 STATUS reads, o_timeout=1, head byte dropped, next byte proceeds.
- Assert i_rst_n=0 during WR_DATA with i_rdy=0 → strobes 0 immediately, o_level=0, o_busy=0.
- UART_RX_POLL_EN: status returns 16'h0002, DATA returns 16'h0077 → o_rx_valid=1, o_rx_data=8'h77, then write 16'h0002 to 16'h8302.

Source files
------------

// File: rtl/uart_tx_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
// Bus request is carried as one packed struct so the registered strobes update together.
package uart_sched_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_STAT = 3'd1,
    CHK     = 3'd2,
    WR_DATA = 3'd3,
    RD_DATA = 3'd4,
    CLR_RX  = 3'd5
  } state_t;

  localparam logic [15:0] UART_DATA_OFF = 16'h0000;
  localparam logic [15:0] UART_STAT_OFF = 16'h0002;
  localparam int          STAT_TX_BUSY  = 0;
  localparam int          STAT_RX_PEND  = 1;
  localparam logic [15:0] RX_CLR_WORD   = 16'h0002;

  typedef struct packed {
    logic        sel;
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/uart_tx_sched_fifo.sv
// Byte FIFO with occupancy count; a push while full is refused even if a pop happens.
// Single-cycle push/pop, combinational head read; no bus knowledge.
module sync_fifo_byte #(
  parameter int DEPTH = 8
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_push,
  input  logic [7:0]                     i_data,
  input  logic                           i_pop,
  output logic [7:0]                     o_data,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH + 1);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign o_full  = (level == LW'(DEPTH));
  assign o_empty = (level == '0);
  assign o_level = level;
  assign o_data  = mem[rd_ptr];

  assign do_push = i_push & ~o_full;
  assign do_pop  = i_pop & ~o_empty;

  always_ff @(posedge i_clk) begin
    if (do_push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Drains a byte FIFO to the UART over the peripheral bus, polling STATUS.tx_busy before each DATA write.
// Bus strobes are registered and held until i_rdy; optional RX polling under `UART_RX_POLL_EN.
module uart_tx_sched
  import uart_sched_pkg::*;
#(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] UART_BASE  = 16'h8300,
  parameter int          POLL_LIMIT = 4096
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_push,
  input  logic [7:0]                        i_push_data,
  output logic                              o_full,
  output logic                              o_empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_level,
  output logic                              o_busy,
  output logic                              o_ovf,
  output logic                              o_timeout,
  input  logic                              i_clr_err,
  output logic                              o_sel,
  output logic                              o_we,
  output logic                              o_re,
  output logic [15:0]                       o_addr,
  output logic [15:0]                       o_wdata,
  input  logic [15:0]                       i_rdata,
  input  logic                              i_rdy
`ifdef UART_RX_POLL_EN
  ,
  output logic                              o_rx_valid,
  output logic [7:0]                        o_rx_data,
  input  logic                              i_rx_ready
`endif
);

  localparam int CW = (POLL_LIMIT > 1) ? $clog2(POLL_LIMIT) : 1;

  state_t        state;
  state_t        state_nxt;
  bus_req_t      req_q;
  bus_req_t      req_d;
  logic [CW-1:0] poll_cnt;
  logic [CW-1:0] poll_cnt_nxt;
  logic [1:0]    stat_q;
  logic [7:0]    head;
  logic          pop;
  logic          tmo_set;
  logic          done;
  logic          ovf_set;
  logic          rdata_unused;

  sync_fifo_byte #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (i_push),
    .i_data  (i_push_data),
    .i_pop   (pop),
    .o_data  (head),
    .o_full  (o_full),
    .o_empty (o_empty),
    .o_level (o_level)
  );

  assign done    = req_q.sel & i_rdy;
  assign ovf_set = i_push & o_full;
  assign o_busy  = (state != IDLE);

`ifdef UART_RX_POLL_EN
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic [5:0] rx_tick_cnt;
  logic       rx_tick;
  logic       rx_latch;

  assign rx_tick    = (state == IDLE) && o_empty && (rx_tick_cnt == 6'd63);
  assign o_rx_valid = rx_valid_q;
  assign o_rx_data  = rx_data_q;
`endif

  always_comb begin
    state_nxt    = state;
    poll_cnt_nxt = poll_cnt;
    pop          = 1'b0;
    tmo_set      = 1'b0;
`ifdef UART_RX_POLL_EN
    rx_latch     = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!o_empty) begin
          state_nxt = RD_STAT;
`ifdef UART_RX_POLL_EN
        end else if (rx_tick) begin
          state_nxt = RD_STAT;
`endif
        end
      end
      RD_STAT: begin
        if (done) state_nxt = CHK;
      end
      CHK: begin
`ifdef UART_RX_POLL_EN
        if (stat_q[STAT_RX_PEND] && !rx_valid_q) begin
          state_nxt = RD_DATA;
        end else
`endif
        if (o_empty) begin
          // Status poll with nothing to send (RX-only visit).
          state_nxt    = IDLE;
          poll_cnt_nxt = '0;
        end else if (!stat_q[STAT_TX_BUSY]) begin
          state_nxt    = WR_DATA;
          poll_cnt_nxt = '0;
        end else if (poll_cnt < CW'(POLL_LIMIT - 1)) begin
          state_nxt    = RD_STAT;
          poll_cnt_nxt = poll_cnt + 1'b1;
        end else begin
          state_nxt    = IDLE;
          poll_cnt_nxt = '0;
          tmo_set      = 1'b1;
          pop          = 1'b1;
        end
      end
      WR_DATA: begin
        if (done) begin
          pop       = 1'b1;
          state_nxt = IDLE;
        end
      end
`ifdef UART_RX_POLL_EN
      RD_DATA: begin
        if (done) begin
          rx_latch  = 1'b1;
          state_nxt = CLR_RX;
        end
      end
      CLR_RX: begin
        if (done) state_nxt = RD_STAT;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // A completing transfer always leaves one idle bus cycle before the next request.
  always_comb begin
    req_d = '0;
    if (!done) begin
      case (state_nxt)
        RD_STAT: begin
          req_d.sel  = 1'b1;
          req_d.re   = 1'b1;
          req_d.addr = UART_BASE + UART_STAT_OFF;
        end
        WR_DATA: begin
          req_d.sel   = 1'b1;
          req_d.we    = 1'b1;
          req_d.addr  = UART_BASE + UART_DATA_OFF;
          req_d.wdata = {8'h00, head};
        end
`ifdef UART_RX_POLL_EN
        RD_DATA: begin
          req_d.sel  = 1'b1;
          req_d.re   = 1'b1;
          req_d.addr = UART_BASE + UART_DATA_OFF;
        end
        CLR_RX: begin
          req_d.sel   = 1'b1;
          req_d.we    = 1'b1;
          req_d.addr  = UART_BASE + UART_STAT_OFF;
          req_d.wdata = RX_CLR_WORD;
        end
`endif
        default: req_d = '0;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      req_q     <= '0;
      poll_cnt  <= '0;
      stat_q    <= '0;
      o_ovf     <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      req_q    <= req_d;
      poll_cnt <= poll_cnt_nxt;
      if (state == RD_STAT && done) begin
        stat_q <= i_rdata[1:0];
      end
      o_ovf     <= ovf_set | (o_ovf & ~i_clr_err);
      o_timeout <= tmo_set | (o_timeout & ~i_clr_err);
    end
  end

`ifdef UART_RX_POLL_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rx_valid_q  <= 1'b0;
      rx_data_q   <= '0;
      rx_tick_cnt <= '0;
    end else begin
      if (rx_latch) begin
        rx_valid_q <= 1'b1;
        rx_data_q  <= i_rdata[7:0];
      end else if (i_rx_ready) begin
        rx_valid_q <= 1'b0;
      end
      if (state == IDLE && o_empty) rx_tick_cnt <= rx_tick_cnt + 6'd1;
      else                          rx_tick_cnt <= '0;
    end
  end

  assign rdata_unused = ^i_rdata[15:8];
`else
  assign rdata_unused = ^{i_rdata[15:2], stat_q[STAT_RX_PEND]};
`endif

  assign o_sel   = req_q.sel;
  assign o_we    = req_q.we;
  assign o_re    = req_q.re;
  assign o_addr  = req_q.addr;
  assign o_wdata = req_q.wdata;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: UART slave model, write scoreboard, vector table plus corner sequences.
module tb_uart_tx_sched;

  localparam int PL = 16;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_push;
  logic [7:0]  i_push_data;
  logic        o_full, o_empty, o_busy, o_ovf, o_timeout;
  logic [3:0]  o_level;
  logic        i_clr_err;
  logic        o_sel, o_we, o_re;
  logic [15:0] o_addr, o_wdata, i_rdata;
  logic        i_rdy;
`ifdef UART_RX_POLL_EN
  logic        o_rx_valid;
  logic [7:0]  o_rx_data;
  logic        i_rx_ready;
`endif

  always #5 i_clk = ~i_clk;

  // Slave model.
  logic       rd_en, wr_en, stuck, rx_pend;
  logic [7:0] rx_byte;
  int         busy_len;
  int         busy_cnt = 0;
  logic       tx_busy;
  assign tx_busy = stuck | (busy_cnt > 0);
  assign i_rdy   = o_sel & (o_re ? rd_en : wr_en);
  assign i_rdata = (o_addr == 16'h8302) ? {14'h0, rx_pend, tx_busy} : {8'h00, rx_byte};

  uart_tx_sched #(.FIFO_DEPTH(8), .UART_BASE(16'h8300), .POLL_LIMIT(PL)) dut (
`ifdef UART_RX_POLL_EN
    .o_rx_valid (o_rx_valid),
    .o_rx_data  (o_rx_data),
    .i_rx_ready (i_rx_ready),
`endif
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (i_push),
    .i_push_data (i_push_data),
    .o_full      (o_full),
    .o_empty     (o_empty),
    .o_level     (o_level),
    .o_busy      (o_busy),
    .o_ovf       (o_ovf),
    .o_timeout   (o_timeout),
    .i_clr_err   (i_clr_err),
    .o_sel       (o_sel),
    .o_we        (o_we),
    .o_re        (o_re),
    .o_addr      (o_addr),
    .o_wdata     (o_wdata),
    .i_rdata     (i_rdata),
    .i_rdy       (i_rdy)
  );

  // Monitor: transfers complete at the next rising edge when o_sel && i_rdy.
  int          n_reads = 0;
  int          n_busy_viol = 0;
  logic [31:0] obs_q[$];
  logic [31:0] exp_q[$];

  always @(negedge i_clk) begin
    if (o_sel && i_rdy && o_re && o_addr == 16'h8302) n_reads++;
    if (o_sel && i_rdy && o_we) begin
      obs_q.push_back({o_addr, o_wdata});
      if (o_addr == 16'h8300 && tx_busy) n_busy_viol++;
    end
    if (o_sel && i_rdy && o_we && o_addr == 16'h8300) busy_cnt = busy_len;
    else if (busy_cnt > 0) busy_cnt--;
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    i_push      = 1'b1;
    i_push_data = d;
    tick();
    i_push      = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int max);
    int n = 0;
    while (!(!o_busy && o_empty) && n < max) begin
      tick();
      n++;
    end
    check({name, "_drain_in_time"}, {31'b0, n < max}, 32'd1);
  endtask

  task automatic compare_writes(input string name);
    logic [31:0] e, a;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_q.size() == 0) begin
        check({name, "_missing_write"}, 32'hDEAD_DEAD, e);
      end else begin
        a = obs_q.pop_front();
        check({name, "_write"}, a, e);
      end
    end
    check({name, "_extra_writes"}, obs_q.size(), 32'd0);
    obs_q.delete();
  endtask

  typedef struct {
    logic [7:0]  data;
    logic [15:0] exp_wdata;
    int          exp_reads;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, fails=%0d", fails);
    $fatal(1);
  end

  initial begin
    int base;
    int n;

    vecs[0] = '{8'h5A, 16'h005A, 1};
    vecs[1] = '{8'h00, 16'h0000, 1};
    vecs[2] = '{8'hFF, 16'h00FF, 1};
    vecs[3] = '{8'hA5, 16'h00A5, 1};
    vecs[4] = '{8'h80, 16'h0080, 1};

    i_rst_n = 1'b0; i_push = 1'b0; i_push_data = '0; i_clr_err = 1'b0;
    rd_en = 1'b1; wr_en = 1'b1; stuck = 1'b0; rx_pend = 1'b0; rx_byte = 8'h00;
    busy_len = 0;
`ifdef UART_RX_POLL_EN
    i_rx_ready = 1'b0;
`endif
    repeat (3) tick();
    check("rst_level", o_level, 0);
    check("rst_empty", o_empty, 1);
    check("rst_full", o_full, 0);
    check("rst_busy", o_busy, 0);
    check("rst_ovf", o_ovf, 0);
    check("rst_timeout", o_timeout, 0);
    check("rst_strobes", {o_sel, o_we, o_re}, 0);
    check("rst_addr", o_addr, 0);
    check("rst_wdata", o_wdata, 0);
    i_rst_n = 1'b1;
    tick();

    // Single bytes with an idle UART: one STATUS read then one DATA write each.
    for (int i = 0; i < 5; i++) begin
      base = n_reads;
      exp_q.push_back({16'h8300, vecs[i].exp_wdata});
      push_byte(vecs[i].data);
      wait_drain($sformatf("vec%0d", i), 50);
      check($sformatf("vec%0d_reads", i), n_reads - base, vecs[i].exp_reads);
      check($sformatf("vec%0d_empty", i), o_empty, 1);
      check($sformatf("vec%0d_busy", i), o_busy, 0);
      compare_writes($sformatf("vec%0d", i));
    end

    // UART busy for 20 cycles after each write: order kept, never written while busy.
    busy_len = 20;
    base = n_reads;
    exp_q.push_back({16'h8300, 16'h0041});
    exp_q.push_back({16'h8300, 16'h0042});
    exp_q.push_back({16'h8300, 16'h0043});
    push_byte(8'h41);
    push_byte(8'h42);
    push_byte(8'h43);
    wait_drain("busy3", 1000);
    check("busy3_no_write_while_busy", n_busy_viol, 0);
    check("busy3_polled", {31'b0, (n_reads - base) > 3}, 1);
    compare_writes("busy3");
    busy_len = 0;
    repeat (25) tick();

    // Overflow with a stalled bus; the 9th push coincides with i_clr_err and must win.
    rd_en = 1'b0;
    wr_en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      i_push      = 1'b1;
      i_push_data = 8'h10 + 8'(i);
      i_clr_err   = (i == 8);
      tick();
      if (i == 7) begin
        check("ovf_full_at8", o_full, 1);
        check("ovf_not_yet", o_ovf, 0);
      end
    end
    i_push = 1'b0;
    i_clr_err = 1'b0;
    check("ovf_level", o_level, 8);
    check("ovf_set", o_ovf, 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("ovf_cleared", o_ovf, 0);
    check("ovf_level_kept", o_level, 8);

    // Reach WR_DATA with writes stalled, then reset asynchronously.
    rd_en = 1'b1;
    n = 0;
    while (!o_we && n < 20) begin
      tick();
      n++;
    end
    check("wr_stall_reached", {31'b0, n < 20}, 1);
    check("wr_stall_addr", o_addr, 16'h8300);
    check("wr_stall_wdata", o_wdata, 16'h0010);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_strobes", {o_sel, o_we, o_re}, 0);
    check("arst_level", o_level, 0);
    check("arst_busy", o_busy, 0);
    check("arst_empty", o_empty, 1);
    tick();
    i_rst_n = 1'b1;
    wr_en = 1'b1;
    tick();
    compare_writes("arst");

    // Stuck tx_busy: exactly PL reads, head dropped, next byte proceeds once released.
    stuck = 1'b1;
    base = n_reads;
    push_byte(8'hA0);
    push_byte(8'hA1);
    n = 0;
    while (!o_timeout && n < 200) begin
      tick();
      n++;
    end
    check("tmo_reached", {31'b0, n < 200}, 1);
    check("tmo_reads", n_reads - base, PL);
    check("tmo_level", o_level, 1);
    stuck = 1'b0;
    exp_q.push_back({16'h8300, 16'h00A1});
    wait_drain("tmo_next", 100);
    compare_writes("tmo");
    check("tmo_sticky", o_timeout, 1);
    i_clr_err = 1'b1;
    tick();
    i_clr_err = 1'b0;
    check("tmo_cleared", o_timeout, 0);

`ifdef UART_RX_POLL_EN
    rx_pend = 1'b1;
    rx_byte = 8'h77;
    n = 0;
    while (!o_rx_valid && n < 200) begin
      tick();
      n++;
    end
    check("rx_valid", {31'b0, n < 200}, 1);
    check("rx_data", o_rx_data, 8'h77);
    rx_pend = 1'b0;
    exp_q.push_back({16'h8302, 16'h0002});
    repeat (20) tick();
    compare_writes("rx");
    i_rx_ready = 1'b1;
    tick();
    i_rx_ready = 1'b0;
    check("rx_cleared", o_rx_valid, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
